// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared definitions for the multi-cycle ALU.
//   * 4-bit operation codes accepted on ALUcontrol
//   * control FSM state encoding (IDLE, MUL, DONE)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_LSL   = 4'b1001;
  localparam logic [3:0] OP_LSR   = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq -- iterative shift-add multiplier datapath (one bit per cycle).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load_i          latch operands, clear accumulator, counter := N-1
//   step_i          perform one shift-add step
//   a_i, b_i        multiplicand / multiplier captured on load_i
//   last_o          the current step is the final one (counter == 0)
//   prod_o          accumulator value after the current step; on the last
//                   step this is the low N bits of a*b
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int N   = 64,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         last_o,
  output logic [N-1:0] prod_o
);

  logic [N-1:0]   acc_q;
  logic [N-1:0]   mcand_q;
  logic [N-1:0]   mplier_q;
  logic [SHW-1:0] cnt_q;

  // Only the low N bits are kept, which is the same for signed and unsigned.
  assign prod_o = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_o = (cnt_q == '0);

  // NOTE: non-blocking (<=) assignments in clocked blocks so every register
  // samples the pre-edge values; the whole datapath is reset so an aborted
  // multiply leaves no stale state behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      cnt_q    <= SHW'(N - 1);
    end else if (step_i) begin
      acc_q    <= prod_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (!last_o) cnt_q <= cnt_q - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU: single-cycle logic/add/sub/shift ops and an
// iterative N-step multiplier, with registered result and flags.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             request, honoured only while ready=1
//   a, b              operands (shift amount is b[SHW-1:0])
//   ALUcontrol        opcode, captured together with start
//   ready             block is idle and can accept start
//   done              one-cycle pulse: result/flags were just updated
//   result            registered result, held until the next done
//   zero, negative    result==0, result[N-1]
//   carry, overflow   ADD/SUB carry-out (NOT borrow for SUB) and signed
//                     overflow; 0 for every other operation
// -----------------------------------------------------------------------------
module alu_mc
  import alu_pkg::*;
#(
  parameter int N   = 64,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUcontrol,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  state_t       state_q;
  logic         ready_q, done_q;
  logic [N-1:0] result_q;
  logic         zero_q, negative_q, carry_q, overflow_q;

  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum_ext;
  logic [N-1:0] alu_res;
  logic         alu_carry, alu_ovf;

  logic         mul_load, mul_step, mul_last;
  logic [N-1:0] mul_prod;

  // SUB is a + ~b + 1 in the same N+1-bit adder; bit N is then NOT borrow.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    is_sub    = (ALUcontrol == OP_SUB);
    b_eff     = is_sub ? ~b : b;
    sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
    alu_res   = '1;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (ALUcontrol)
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_PASSB: alu_res = b;
      OP_LSL:   alu_res = a << b[SHW-1:0];
      OP_LSR:   alu_res = a >> b[SHW-1:0];
      OP_ADD, OP_SUB: begin
        alu_res   = sum_ext[N-1:0];
        alu_carry = sum_ext[N];
        alu_ovf   = (a[N-1] == b_eff[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      default:  alu_res = '1;  // undefined opcodes (MUL never uses this path)
    endcase
  end

  assign mul_load = (state_q == IDLE) && start && (ALUcontrol == OP_MUL);
  assign mul_step = (state_q == MUL);

  alu_mul_seq #(.N(N), .SHW(SHW)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .load_i (mul_load),
    .step_i (mul_step),
    .a_i    (a),
    .b_i    (b),
    .last_o (mul_last),
    .prod_o (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          ready_q <= 1'b0;
          if (ALUcontrol == OP_MUL) begin
            state_q <= MUL;
          end else begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            result_q   <= alu_res;
            zero_q     <= ~|alu_res;
            negative_q <= alu_res[N-1];
            carry_q    <= alu_carry;
            overflow_q <= alu_ovf;
          end
        end
        MUL: if (mul_last) begin
          state_q    <= DONE;
          done_q     <= 1'b1;
          result_q   <= mul_prod;
          zero_q     <= ~|mul_prod;
          negative_q <= mul_prod[N-1];
          carry_q    <= 1'b0;
          overflow_q <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- self-checking bench for alu_mc (N=64 and N=8 instances).
// Directed vector table, hand-written multi-cycle sequences (busy-start
// rejection, reset abort, reset priority) and random operations compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // N=64 instance
  logic        start;
  logic [63:0] a, b, result;
  logic [3:0]  op;
  logic        ready, done, zero, negative, carry, overflow;

  // N=8 instance
  logic        start8;
  logic [7:0]  a8, b8, result8;
  logic [3:0]  op8;
  logic        ready8, done8, zero8, negative8, carry8, overflow8;

  alu_mc #(.N(64)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUcontrol(op),
    .ready(ready), .done(done), .result(result), .zero(zero),
    .negative(negative), .carry(carry), .overflow(overflow)
  );

  alu_mc #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .ALUcontrol(op8),
    .ready(ready8), .done(done8), .result(result8), .zero(zero8),
    .negative(negative8), .carry(carry8), .overflow(overflow8)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: results from plain arithmetic; flags {zero,negative,carry,overflow}.
  function automatic void model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic [3:0] f);
    logic signed [65:0] exact;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (o)
      OP_AND:   r = x & y;
      OP_OR:    r = x | y;
      OP_PASSB: r = y;
      OP_MUL:   r = x * y;
      OP_LSL:   r = x << y[5:0];
      OP_LSR:   r = x >> y[5:0];
      OP_ADD: begin
        r = x + y;
        c = (r < x);  // unsigned sum wrapped
        exact = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
        v = (exact != $signed({{2{r[63]}}, r}));
      end
      OP_SUB: begin
        r = x - y;
        c = (x >= y);  // no borrow
        exact = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
        v = (exact != $signed({{2{r[63]}}, r}));
      end
      default:  r = '1;
    endcase
    f = {(r == 64'd0), r[63], c, v};
  endfunction

  // Issue one operation on the 64-bit DUT; called and returning #1 after a
  // rising edge with the DUT idle. lat = cycles from accepting edge to done.
  task automatic run64(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] r, output logic [3:0] f, output int lat);
    check("ready_before_start", ready, 1'b1);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    f = {zero, negative, carry, overflow};
    @(posedge clk); #1;
    check("done_single_pulse", done, 1'b0);
    check("ready_after_done", ready, 1'b1);
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      output logic [7:0] r, output logic [3:0] f, output int lat);
    check("ready8_before_start", ready8, 1'b1);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result8;
    f = {zero8, negative8, carry8, overflow8};
    @(posedge clk); #1;
    check("done8_single_pulse", done8, 1'b0);
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  flags;  // {zero, negative, carry, overflow}
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  logic [3:0] legal_ops [8];

  initial begin
    logic [63:0] r, er, ra, rb;
    logic [3:0]  f, ef, ro;
    logic [7:0]  r8;
    int          lat, busy_ready, dones;

    vecs[0]  = '{OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0101};
    vecs[1]  = '{OP_SUB,   64'd5, 64'd5, 64'd0, 4'b1010};
    vecs[2]  = '{OP_SUB,   64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100};
    vecs[3]  = '{OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100};
    vecs[4]  = '{OP_LSL,   64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b0100};
    vecs[5]  = '{OP_LSR,   64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 4'b0000};
    vecs[6]  = '{OP_MUL,   64'd12345, 64'd678, 64'd8369910, 4'b0000};
    vecs[7]  = '{OP_AND,   64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'h00F0_00F0_00F0_00F0, 4'b0000};
    vecs[8]  = '{OP_OR,    64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'hFFF0_FFF0_FFF0_FFF0, 4'b0100};
    vecs[9]  = '{OP_PASSB, 64'd123, 64'd0, 64'd0, 4'b1000};
    vecs[10] = '{4'b1111,  64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
    vecs[11] = '{4'b0011,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
    vecs[12] = '{OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1010};
    vecs[13] = '{OP_SUB,   64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[14] = '{OP_LSL,   64'd1, 64'h41, 64'd2, 4'b0000};
    vecs[15] = '{OP_PASSB, 64'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b0100};

    legal_ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_MUL, OP_LSL, OP_LSR};

    // ---- reset state ----
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_ready", ready, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 64'd0);
    check("reset_flags", {zero, negative, carry, overflow}, 4'b1000);
    check("reset8_result", result8, 8'd0);

    // ---- directed vector table ----
    for (int i = 0; i < NVEC; i++) begin
      run64(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
      check($sformatf("vec%0d_latency", i), lat, (vecs[i].op == OP_MUL) ? 65 : 1);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_flags", i), f, vecs[i].flags);
    end

    // ---- MUL with start pulses and operand churn while busy ----
    op = OP_MUL; a = 64'd12345; b = 64'd678; start = 1'b1;
    @(posedge clk); #1;
    lat = 1; busy_ready = 0;
    while (!done && lat < 100) begin
      start = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = OP_ADD;
      if (ready) busy_ready++;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("busy_mul_latency", lat, 65);
    check("busy_mul_result", result, 64'd8369910);
    check("busy_ready_low", busy_ready, 0);
    dones = 0;
    repeat (6) begin @(posedge clk); #1; if (done) dones++; end
    check("busy_start_not_queued", dones, 0);
    check("busy_idle_ready", ready, 1'b1);

    // ---- reset 10 cycles into MUL aborts without done ----
    op = OP_MUL; a = 64'h1234; b = 64'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 64'd0);
    check("abort_zero", zero, 1'b1);
    dones = 0;
    repeat (80) begin @(posedge clk); #1; if (done) dones++; end
    check("abort_no_done", dones, 0);
    run64(OP_ADD, 64'd2, 64'd3, r, f, lat);
    check("post_abort_add", r, 64'd5);
    check("post_abort_latency", lat, 1);

    // ---- reset wins over start in the same cycle ----
    op = OP_ADD; a = 64'd7; b = 64'd8; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("prio_result", result, 64'd0);
    check("prio_done", done, 1'b0);
    check("prio_ready", ready, 1'b1);
    @(posedge clk); #1;
    check("prio_no_late_done", done, 1'b0);

    // ---- random operations against the model ----
    for (int i = 0; i < 150; i++) begin
      int k;
      k  = $urandom_range(0, 8);
      ro = (k == 8) ? 4'($urandom_range(0, 15)) : legal_ops[k];
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
      model(ro, ra, rb, er, ef);
      run64(ro, ra, rb, r, f, lat);
      check($sformatf("rand%0d_op%0h_result", i, ro), r, er);
      check($sformatf("rand%0d_op%0h_flags", i, ro), f, ef);
      check($sformatf("rand%0d_op%0h_latency", i, ro), lat, (ro == OP_MUL) ? 65 : 1);
    end

    // ---- N=8 instance ----
    run8(4'b1111, 8'd3, 8'd4, r8, f, lat);
    check("n8_undef_result", r8, 8'hFF);
    check("n8_undef_flags", f, 4'b0100);
    check("n8_undef_latency", lat, 1);
    run8(OP_MUL, 8'd16, 8'd17, r8, f, lat);
    check("n8_mul_result", r8, 8'h10);
    check("n8_mul_latency", lat, 9);
    run8(OP_ADD, 8'h7F, 8'h01, r8, f, lat);
    check("n8_add_result", r8, 8'h80);
    check("n8_add_flags", f, 4'b0101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: N, 64, operand and result width in bits; legal values 8..64, power of two.
REQ-002 Parameter: SHW, $clog2(N), shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when ready=1.
REQ-006 a  input  N  first operand.
REQ-007 b  input  N  second operand.
REQ-008 ALUcontrol  input  4  operation code, captured with start.
REQ-009 ready  output  1  high when the block can accept start.
REQ-010 done  output  1  one-cycle pulse; result and flags are new this cycle.
REQ-011 result  output  N  registered result, held until the next done.
REQ-012 zero  output  1  registered; 1 iff result == 0.
REQ-013 negative  output  1  registered; result[N-1].
REQ-014 carry  output  1  registered; carry-out for ADD, NOT borrow for SUB, else 0.
REQ-015 overflow  output  1  registered; signed overflow for ADD/SUB, else 0.

Function
REQ-016 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 PASSB, 1000 MUL, 1001 LSL (a << b[SHW-1:0]), 1010 LSR (logical a >> b[SHW-1:0]).
REQ-017 Any other opcode SHALL produce result = all ones, zero=0, negative=1, carry=0, overflow=0, with single-cycle latency.
REQ-018 FSM states SHALL be IDLE, MUL, DONE; ready=1 only in IDLE.
REQ-019 IDLE: start=1 with a non-MUL opcode SHALL compute and register result/flags, go to DONE; done=1 in the next cycle (latency 1).
REQ-020 IDLE: start=1 with MUL SHALL latch a, b, clear accumulator, load iteration counter N-1, go to MUL.
REQ-021 MUL: one shift-add step per cycle (accumulator += multiplicand if multiplier LSB=1; multiplicand <<1; multiplier >>1); after the step with counter=0, go to DONE.
REQ-022 MUL result SHALL be the low N bits of a*b (unsigned, equal to signed low half); latency N+1 cycles from accepting edge to done.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; ready=0 in DONE.
REQ-024 start while ready=0 SHALL be ignored and not queued; operand/opcode changes during MUL SHALL not affect the result.
REQ-025 ADD/SUB arithmetic SHALL use an N+1-bit sum; overflow = operand signs equal (b inverted for SUB) and result sign differs.
REQ-026 result and flags SHALL change only on the cycle done rises (or reset).

Reset
REQ-027 reset=1 SHALL force state IDLE, ready=1, done=0, result=0, zero=1, negative=0, carry=0, overflow=0, counter=0 on the next edge.
REQ-028 reset during MUL or DONE SHALL abort the operation with no done pulse; reset has priority over start in the same cycle.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants and the state enum (IDLE, MUL, DONE).
REQ-030 The iterative multiplier datapath (accumulator, shifted operands, counter) SHALL be sub-module alu_mul_seq with load/step/last signals; the FSM, single-cycle ops and flag logic stay in alu_mc.

Verification (N=64 unless stated)
REQ-031 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> done 1 cycle later, result=0x8000_0000_0000_0000, overflow=1, negative=1, carry=0, zero=0.
REQ-032 SUB a=5, b=5 -> result=0, zero=1, carry=1; SUB a=3, b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, carry=0, negative=1.
REQ-033 MUL a=12345, b=678 -> done exactly 65 cycles after accept, result=8369910; start pulses during MUL ignored, ready=0 throughout.
REQ-034 MUL a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> result=0xFFFF_FFFF_FFFF_FFFE; LSL a=1, b=63 -> 0x8000_0000_0000_0000; LSR a=0x8000_0000_0000_0000, b=4 -> 0x0800_0000_0000_0000.
REQ-035 reset asserted 10 cycles into MUL -> no done pulse, next-cycle ready=1, result=0, zero=1; new ADD 2+3 then yields 5.
REQ-036 N=8 instance: opcode 1111 -> result=0xFF; MUL a=16, b=17 -> result=0x10 after 9 cycles.
